// File: rtl/ps_uretici_pkg.sv
// Shared types and constants for the fetch-address generator and its instruction queue.
package ps_uretici_pkg;

  typedef enum logic [1:0] {
    SorunYok      = 2'b00,
    Atlamamaliydi = 2'b01,
    Atlamaliydi   = 2'b10,
    YanlisAtladi  = 2'b11
  } hata_e;

  typedef enum logic [1:0] {
    StBosta,
    StBekle,
    StIptal
  } durum_e;

  // PC values are halfword addresses (byte address bits [31:1]).
  localparam logic [31:1] ResetPs  = 31'h2000_0000;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [2:0]  CFunctJ  = 3'b101;

  typedef struct packed {
    logic [31:0] buyruk;
    logic [31:1] ps;
    logic        atladi;
  } kuyruk_girdi_t;

  function automatic logic [31:1] ps_ilerlet(input logic [31:1] ps, input logic ctipi);
    return ps + (ctipi ? 31'd1 : 31'd2);
  endfunction

endpackage

// File: rtl/getir_kuyrugu.sv
// Two-entry fetch queue with registered storage; the head entry drives the decode outputs.
module getir_kuyrugu
  import ps_uretici_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  kuyruk_girdi_t push_veri_i,
  input  logic          pop_i,
  output kuyruk_girdi_t bas_o,
  output logic          gecerli_o,
  output logic [1:0]    sayi_o
);

  kuyruk_girdi_t mem_q [2];
  logic          yaz_q, oku_q;
  logic [1:0]    sayi_q, sayi_d;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && (sayi_q != 2'd2);
  assign pop_ok  = pop_i && (sayi_q != 2'd0);

  always_comb begin
    sayi_d = sayi_q;
    if (flush_i) begin
      sayi_d = 2'd0;
    end else if (push_ok && !pop_ok) begin
      sayi_d = sayi_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      sayi_d = sayi_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      yaz_q    <= 1'b0;
      oku_q    <= 1'b0;
      sayi_q   <= 2'd0;
    end else begin
      sayi_q <= sayi_d;
      if (flush_i) begin
        yaz_q <= 1'b0;
        oku_q <= 1'b0;
      end else begin
        if (push_ok) begin
          mem_q[yaz_q] <= push_veri_i;
          yaz_q        <= ~yaz_q;
        end
        if (pop_ok) begin
          oku_q <= ~oku_q;
        end
      end
    end
  end

  assign bas_o     = mem_q[oku_q];
  assign gecerli_o = (sayi_q != 2'd0);
  assign sayi_o    = sayi_q;

endmodule

// File: rtl/ps_uretici.sv
// Fetch-address generator: issues one instruction-memory request at a time, predecodes the
// response for the branch predictor, queues instructions for decode and applies redirects.
module ps_uretici
  import ps_uretici_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ddb_durdur_i,
  input  logic [1:0]  hata_duzelt_i,
  input  logic [31:1] yrt_ps_i,
  input  logic        yrt_buyruk_ctipi_i,
  input  logic [31:1] atlanan_ps_i,
  input  logic [31:1] ongorulen_ps_i,
  input  logic        ongorulen_ps_gecerli_i,
  output logic [31:1] ps_o,
  output logic        tahmin_et_o,
  output logic        buyruk_ctipi_o,
  output logic        buyruk_jtipi_o,
  output logic [31:1] l1b_adr_o,
  output logic        l1b_istek_o,
  input  logic        l1b_hazir_i,
  input  logic        l1b_gecerli_i,
  input  logic [31:0] l1b_buyruk_i,
  output logic [31:0] buyruk_o,
  output logic [31:1] buyruk_ps_o,
  output logic        buyruk_gecerli_o,
  output logic        buyruk_atladi_o
);

  durum_e        durum_q, durum_d;
  logic [31:1]   ps_q, ps_d;
  hata_e         hata;
  logic          ctipi, jtipi, dallanma, tahmin, atladi;
  logic          ates, yonlendir, push;
  logic [31:1]   yonlendir_ps, sonraki_ps;
  logic [1:0]    kuyruk_sayi;
  logic          kuyruk_gecerli;
  kuyruk_girdi_t yeni_girdi, bas;

  assign hata = hata_e'(hata_duzelt_i);

  // Predecode of the memory response.
  assign ctipi    = (l1b_buyruk_i[1:0] != 2'b11);
  assign jtipi    = ctipi ? ((l1b_buyruk_i[1:0] == 2'b01) && (l1b_buyruk_i[15:13] == CFunctJ))
                          : (l1b_buyruk_i[6:0] == OpJal);
  assign dallanma = ctipi ? ((l1b_buyruk_i[1:0] == 2'b01) && (l1b_buyruk_i[15:14] == 2'b11))
                          : (l1b_buyruk_i[6:0] == OpBranch);
  assign tahmin   = (jtipi || dallanma) && l1b_gecerli_i && (durum_q == StBekle);
  assign atladi   = tahmin && ongorulen_ps_gecerli_i;

  assign sonraki_ps = atladi ? ongorulen_ps_i : ps_ilerlet(ps_q, ctipi);

  always_comb begin
    yonlendir_ps = atlanan_ps_i;
    if (hata == Atlamamaliydi) begin
      yonlendir_ps = ps_ilerlet(yrt_ps_i, yrt_buyruk_ctipi_i);
    end
  end

  // Requests only start with queue room, so an accepted response always fits.
  assign l1b_istek_o = rst_ni && (durum_q == StBosta) && (kuyruk_sayi != 2'd2);
  assign ates        = l1b_istek_o && l1b_hazir_i;
  assign yonlendir   = (hata != SorunYok) && !ddb_durdur_i;
  assign push        = (durum_q == StBekle) && l1b_gecerli_i && !yonlendir;

  always_comb begin
    durum_d = durum_q;
    ps_d    = ps_q;
    unique case (durum_q)
      StBosta: begin
        // A request leaving together with a redirect carries a stale address.
        if (ates) begin
          durum_d = yonlendir ? StIptal : StBekle;
        end
      end
      StBekle: begin
        if (l1b_gecerli_i) begin
          durum_d = StBosta;
          ps_d    = sonraki_ps;
        end else if (yonlendir) begin
          durum_d = StIptal;
        end
      end
      StIptal: begin
        if (l1b_gecerli_i) begin
          durum_d = StBosta;
        end
      end
      default: durum_d = StBosta;
    endcase
    if (yonlendir) begin
      ps_d = yonlendir_ps;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q <= StBosta;
      ps_q    <= ResetPs;
    end else begin
      durum_q <= durum_d;
      ps_q    <= ps_d;
    end
  end

  assign yeni_girdi = '{buyruk: l1b_buyruk_i, ps: ps_q, atladi: atladi};

  getir_kuyrugu u_kuyruk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (yonlendir),
    .push_i     (push),
    .push_veri_i(yeni_girdi),
    .pop_i      (kuyruk_gecerli && !ddb_durdur_i),
    .bas_o      (bas),
    .gecerli_o  (kuyruk_gecerli),
    .sayi_o     (kuyruk_sayi)
  );

  assign ps_o             = ps_q;
  assign l1b_adr_o        = ps_q;
  assign tahmin_et_o      = tahmin;
  assign buyruk_ctipi_o   = ctipi;
  assign buyruk_jtipi_o   = jtipi;
  assign buyruk_o         = bas.buyruk;
  assign buyruk_ps_o      = bas.ps;
  assign buyruk_atladi_o  = bas.atladi;
  assign buyruk_gecerli_o = kuyruk_gecerli;

endmodule
